bnn_xnor_output_layer: RTL and testbench

- Binary (XNOR-popcount) layer directly downstream of the 8-bit hybrid input layer.
- Consumes that layer's IN_WIDTH-bit binarised activation vector and its done flag (as in_valid).
- For each of OUT_WIDTH neurons, computes popcount(XNOR(activation, weight row)) over IN_WIDTH / PARALLEL_BITS cycles, then:
  - thresholds the count into one output bit;
  - tracks the arg-max neuron as the classification result.

---
 rtl/bnn_xnor_output_layer_if.sv | 26 ++
 rtl/bnn_xnor_output_layer.sv | 143 ++++++++++++++
 tb/tb_bnn_xnor_output_layer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_xnor_output_layer_if.sv
// Activation-in / classification-out handshake bundle for the binary output layer.
interface bnn_xnor_output_layer_if #(
  parameter int IN_WIDTH  = 128,
  parameter int OUT_WIDTH = 10,
  parameter int CNT_WIDTH = $clog2(IN_WIDTH) + 1,
  parameter int IDX_WIDTH = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1
);
  logic [IN_WIDTH-1:0]  in_bits;
  logic                 in_valid;
  logic                 in_ready;
  logic [OUT_WIDTH-1:0] out;
  logic [IDX_WIDTH-1:0] class_idx;
  logic [CNT_WIDTH-1:0] max_score;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_bits, in_valid, out_ready,
    input  in_ready, out, class_idx, max_score, out_valid
  );

  modport slave (
    input  in_bits, in_valid, out_ready,
    output in_ready, out, class_idx, max_score, out_valid
  );
endinterface

// File: rtl/bnn_xnor_output_layer.sv
// Binary XNOR-popcount layer: scores each neuron a chunk per cycle, thresholds it,
// and tracks the arg-max neuron; results are held under out_valid until out_ready.
module bnn_xnor_output_layer #(
  parameter int    IN_WIDTH      = 128,
  parameter int    OUT_WIDTH     = 10,
  parameter int    PARALLEL_BITS = 32,
  parameter int    CNT_WIDTH     = $clog2(IN_WIDTH) + 1,
  parameter string WEIGHT_FILE   = "bnn_weights.mem",
  parameter string THRESH_FILE   = "bnn_thresh.mem"
) (
  input logic                    clk,
  input logic                    reset,
  bnn_xnor_output_layer_if.slave bus
);
  localparam int CYCLES_PER_NEURON = IN_WIDTH / PARALLEL_BITS;
  localparam int IDX_WIDTH = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int CYC_WIDTH = (CYCLES_PER_NEURON > 1) ? $clog2(CYCLES_PER_NEURON) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_NEURON = IDX_WIDTH'(OUT_WIDTH - 1);
  localparam logic [CYC_WIDTH-1:0] LAST_CHUNK  = CYC_WIDTH'(CYCLES_PER_NEURON - 1);

  if (IN_WIDTH % PARALLEL_BITS != 0) begin : g_bad_lanes
    $error("PARALLEL_BITS must divide IN_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  logic [IN_WIDTH-1:0]  weight_mem [OUT_WIDTH];
  logic [CNT_WIDTH-1:0] thresh_mem [OUT_WIDTH];

  state_t               state_q, state_d;
  logic [IN_WIDTH-1:0]  buf_q;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_WIDTH-1:0] neuron_idx_q, neuron_idx_d;
  logic [CYC_WIDTH-1:0] cycle_count_q, cycle_count_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [IDX_WIDTH-1:0] class_idx_q, class_idx_d;
  logic [CNT_WIDTH-1:0] max_score_q, max_score_d;
  logic                 out_valid_q, out_valid_d;
  logic                 capture;

  logic [IN_WIDTH-1:0]      weight_row;
  logic [PARALLEL_BITS-1:0] chunk_xnor;
  logic [CNT_WIDTH-1:0]     chunk_pop;
  logic [CNT_WIDTH-1:0]     next_total;

  assign weight_row = weight_mem[neuron_idx_q];
  assign chunk_xnor = ~(buf_q[int'(cycle_count_q) * PARALLEL_BITS +: PARALLEL_BITS]
                      ^ weight_row[int'(cycle_count_q) * PARALLEL_BITS +: PARALLEL_BITS]);

  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < PARALLEL_BITS; i++) begin
      chunk_pop = chunk_pop + CNT_WIDTH'(chunk_xnor[i]);
    end
  end

  // Cannot overflow: the full-row sum is at most IN_WIDTH, which CNT_WIDTH holds.
  assign next_total = acc_q + chunk_pop;

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    neuron_idx_d  = neuron_idx_q;
    cycle_count_d = cycle_count_q;
    out_d         = out_q;
    class_idx_d   = class_idx_q;
    max_score_d   = max_score_q;
    out_valid_d   = out_valid_q;
    capture       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          capture       = 1'b1;
          acc_d         = '0;
          neuron_idx_d  = '0;
          cycle_count_d = '0;
          state_d       = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cycle_count_q != LAST_CHUNK) begin
          acc_d         = next_total;
          cycle_count_d = cycle_count_q + CYC_WIDTH'(1);
        end else begin
          out_d[neuron_idx_q] = (next_total >= thresh_mem[neuron_idx_q]);
          // Strict compare keeps the lowest index on ties; neuron 0 always seeds the max.
          if (neuron_idx_q == '0 || next_total > max_score_q) begin
            max_score_d = next_total;
            class_idx_d = neuron_idx_q;
          end
          acc_d         = '0;
          cycle_count_d = '0;
          if (neuron_idx_q == LAST_NEURON) begin
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            neuron_idx_d = neuron_idx_q + IDX_WIDTH'(1);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      neuron_idx_q  <= '0;
      cycle_count_q <= '0;
      out_q         <= '0;
      class_idx_q   <= '0;
      max_score_q   <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      neuron_idx_q  <= neuron_idx_d;
      cycle_count_q <= cycle_count_d;
      out_q         <= out_d;
      class_idx_q   <= class_idx_d;
      max_score_q   <= max_score_d;
      out_valid_q   <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) buf_q <= bus.in_bits;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out       = out_q;
  assign bus.class_idx = class_idx_q;
  assign bus.max_score = max_score_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_bnn_xnor_output_layer.sv
// Bench for the binary output layer: directed table plus randomized vectors scored by a popcount model.
module tb_bnn_xnor_output_layer;
  localparam int IW = 128;
  localparam int OW = 10;
  localparam int CW = 8;
  localparam int XW = 4;
  localparam int LAT = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bnn_xnor_output_layer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

  bnn_xnor_output_layer #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .PARALLEL_BITS(32), .CNT_WIDTH(CW),
    .WEIGHT_FILE(""), .THRESH_FILE("")
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [IW-1:0]          in;
    logic [OW-1:0][IW-1:0]  w;
    logic [OW-1:0][CW-1:0]  th;
    logic [OW-1:0]          e_out;
    logic [XW-1:0]          e_cls;
    logic [CW-1:0]          e_ms;
  } vec_t;

  vec_t                  tbl [6];
  logic [OW-1:0][IW-1:0] cur_w;
  logic [OW-1:0][CW-1:0] cur_t;
  int tests = 0;
  int errors = 0;

  task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_mem();
    for (int n = 0; n < OW; n++) begin
      dut.weight_mem[n] = cur_w[n];
      dut.thresh_mem[n] = cur_t[n];
    end
  endtask

  // Reference: score = agreeing bits; out bit = score >= threshold; winner = first maximum.
  task automatic model(input logic [IW-1:0] v, output logic [OW-1:0] o,
                       output logic [XW-1:0] ci, output logic [CW-1:0] ms);
    int best;
    best = -1;
    o = '0; ci = '0; ms = '0;
    for (int n = 0; n < OW; n++) begin
      int s;
      s = $countones(~(v ^ cur_w[n]));
      o[n] = (s >= int'(cur_t[n]));
      if (s > best) begin
        best = s;
        ci = XW'(n);
        ms = CW'(s);
      end
    end
  endtask

  task automatic run_vec(input logic [IW-1:0] v, input bit hold_rdy, output logic [OW-1:0] o,
                         output logic [XW-1:0] ci, output logic [CW-1:0] ms, output int lat);
    @(negedge clk);
    bus.in_bits   = v;
    bus.in_valid  = 1'b1;
    bus.out_ready = hold_rdy;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_drop", IW'(bus.in_ready), IW'(1'b0));
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    o  = bus.out;
    ci = bus.class_idx;
    ms = bus.max_score;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after_hs", IW'(bus.in_ready), IW'(1'b1));
    check("out_valid_after_hs", IW'(bus.out_valid), IW'(1'b0));
  endtask

  task automatic run_and_check(input string tag, input logic [IW-1:0] v, input bit hold_rdy,
                               input logic [OW-1:0] eo, input logic [XW-1:0] ec,
                               input logic [CW-1:0] em);
    logic [OW-1:0] o;
    logic [XW-1:0] ci;
    logic [CW-1:0] ms;
    int lat;
    run_vec(v, hold_rdy, o, ci, ms, lat);
    check({tag, "_out"}, IW'(o), IW'(eo));
    check({tag, "_class"}, IW'(ci), IW'(ec));
    check({tag, "_score"}, IW'(ms), IW'(em));
    check({tag, "_latency"}, IW'(lat), IW'(LAT));
  endtask

  initial begin
    logic [IW-1:0] pa, agree70, newdata;
    logic [OW-1:0] eo;
    logic [XW-1:0] ec;
    logic [CW-1:0] em;
    int lat;

    bus.in_bits = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    pa = {32{4'hA}};
    agree70 = '0;
    for (int k = 0; k < 70; k++) agree70[k] = 1'b1;

    for (int i = 0; i < 6; i++) begin
      for (int n = 0; n < OW; n++) begin
        tbl[i].w[n]  = '1;
        tbl[i].th[n] = CW'(64);
      end
    end
    tbl[0].in = '1; tbl[0].e_out = 10'h3FF; tbl[0].e_cls = 4'd0; tbl[0].e_ms = 8'd128;
    tbl[1].in = '0; tbl[1].e_out = 10'h000; tbl[1].e_cls = 4'd0; tbl[1].e_ms = 8'd0;
    tbl[2].in = '0; tbl[2].th[3] = '0;
    tbl[2].e_out = 10'h008; tbl[2].e_cls = 4'd0; tbl[2].e_ms = 8'd0;
    tbl[3].in = pa;
    for (int n = 0; n < OW; n++) begin
      tbl[3].w[n]  = (n == 7) ? pa : ~pa;
      tbl[3].th[n] = CW'(128);
    end
    tbl[3].e_out = 10'h080; tbl[3].e_cls = 4'd7; tbl[3].e_ms = 8'd128;
    tbl[4].in = '0; tbl[4].w[2] = ~agree70; tbl[4].th[2] = CW'(70);
    tbl[4].e_out = 10'h004; tbl[4].e_cls = 4'd2; tbl[4].e_ms = 8'd70;
    tbl[5] = tbl[4];
    tbl[5].th[2] = CW'(71);
    tbl[5].e_out = 10'h000;

    repeat (3) @(negedge clk);
    check("rst_in_ready", IW'(bus.in_ready), IW'(1'b1));
    check("rst_out_valid", IW'(bus.out_valid), IW'(1'b0));
    check("rst_out", IW'(bus.out), IW'(0));
    check("rst_class", IW'(bus.class_idx), IW'(0));
    check("rst_score", IW'(bus.max_score), IW'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cur_w = tbl[i].w;
      cur_t = tbl[i].th;
      load_mem();
      run_and_check($sformatf("vec%0d", i), tbl[i].in, 1'b0, tbl[i].e_out, tbl[i].e_cls, tbl[i].e_ms);
    end

    for (int it = 0; it < 12; it++) begin
      logic [IW-1:0] v;
      for (int n = 0; n < OW; n++) begin
        for (int j = 0; j < 4; j++) cur_w[n][j*32 +: 32] = $urandom();
        cur_t[n] = CW'($urandom_range(50, 78));
      end
      if (it % 3 == 0) cur_w[5] = cur_w[2];
      for (int j = 0; j < 4; j++) v[j*32 +: 32] = $urandom();
      if (it % 2 == 1) v = cur_w[$urandom_range(0, OW-1)] ^ IW'($urandom_range(0, 255));
      load_mem();
      model(v, eo, ec, em);
      run_and_check($sformatf("rand%0d", it), v, it[0], eo, ec, em);
    end

    // Reset in the middle of a run wipes every output immediately.
    cur_w = tbl[0].w;
    cur_t = tbl[0].th;
    load_mem();
    @(negedge clk);
    bus.in_bits = tbl[0].in;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", IW'(bus.out_valid), IW'(1'b0));
    check("midrst_out", IW'(bus.out), IW'(0));
    check("midrst_class", IW'(bus.class_idx), IW'(0));
    check("midrst_score", IW'(bus.max_score), IW'(0));
    check("midrst_in_ready", IW'(bus.in_ready), IW'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("after_rst", tbl[0].in, 1'b0, tbl[0].e_out, tbl[0].e_cls, tbl[0].e_ms);

    // Backpressure with new input offered throughout compute and done.
    cur_w = tbl[3].w;
    cur_t = tbl[3].th;
    load_mem();
    newdata = '1;
    @(negedge clk);
    bus.in_bits = tbl[3].in;
    bus.in_valid = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      bus.in_valid = ~bus.in_valid;
      bus.in_bits = newdata;
      @(negedge clk);
      lat++;
    end
    check("bp_latency", IW'(lat), IW'(LAT));
    bus.in_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      check($sformatf("bp_valid_c%0d", c), IW'(bus.out_valid), IW'(1'b1));
      check($sformatf("bp_out_c%0d", c), IW'(bus.out), IW'(tbl[3].e_out));
      check($sformatf("bp_class_c%0d", c), IW'(bus.class_idx), IW'(tbl[3].e_cls));
      check($sformatf("bp_score_c%0d", c), IW'(bus.max_score), IW'(tbl[3].e_ms));
      check($sformatf("bp_in_ready_c%0d", c), IW'(bus.in_ready), IW'(1'b0));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    check("bp_in_ready_after_hs", IW'(bus.in_ready), IW'(1'b1));
    check("bp_out_valid_after_hs", IW'(bus.out_valid), IW'(1'b0));
    check("bp_out_held", IW'(bus.out), IW'(tbl[3].e_out));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
